// File: rtl/snake_motion_ctrl.sv
// Snake head motion: synchronises keyboard direction codes, blocks 180-degree turns,
// paces moves with a step timer and tracks the head position with grid wrap-around.
module snake_motion_ctrl #(
   parameter int TICK_CYCLES = 1_250_000,
   parameter int GRID_W      = 40,
   parameter int GRID_H      = 30,
   parameter int XW          = 6,
   parameter int YW          = 5,
   parameter int START_X     = 20,
   parameter int START_Y     = 15
) (
   input  logic          clk_25,
   input  logic          rst,
   input  logic [2:0]    direction,
   input  logic          game_over,
   input  logic          restart,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic [1:0]    cur_dir,
   output logic          step,
   output logic          running
);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   state_t        state, state_n;
   logic [2:0]    s1, s2, s3;
   logic [TW-1:0] timer, timer_n;
   logic [1:0]    pending, pending_n, cur_dir_n;
   logic [XW-1:0] x_n, mv_x;
   logic [YW-1:0] y_n, mv_y;
   logic          step_n;
   logic          cand_vld;
   logic [1:0]    cand;

   // A code is only trusted once two consecutive synchronised samples agree.
   assign cand     = s3[1:0];
   assign cand_vld = (s2 == s3) && !s3[2];

   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         s1 <= 3'd4;
         s2 <= 3'd4;
         s3 <= 3'd4;
      end else begin
         s1 <= direction;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Head one cell along pending, wrapping at each grid edge.
   always_comb begin
      mv_x = head_x;
      mv_y = head_y;
      unique case (pending)
         2'd0: mv_y = (head_y == YW'(GRID_H-1)) ? '0 : head_y + 1'b1;
         2'd1: mv_x = (head_x == XW'(GRID_W-1)) ? '0 : head_x + 1'b1;
         2'd2: mv_x = (head_x == '0) ? XW'(GRID_W-1) : head_x - 1'b1;
         2'd3: mv_y = (head_y == '0) ? YW'(GRID_H-1) : head_y - 1'b1;
      endcase
   end

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      pending_n = pending;
      cur_dir_n = cur_dir;
      x_n       = head_x;
      y_n       = head_y;
      step_n    = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (cand_vld) begin
               pending_n = cand;
               cur_dir_n = cand;
               state_n   = RUN;
            end
         end
         RUN: begin
            if (game_over) begin
               state_n = OVER;
               timer_n = '0;
            end else begin
               // Reversal is judged against the applied direction, not pending.
               if (cand_vld && (cand != ~cur_dir))
                  pending_n = cand;
               if (timer == TW'(TICK_CYCLES-1)) begin
                  timer_n   = '0;
                  cur_dir_n = pending;
                  x_n       = mv_x;
                  y_n       = mv_y;
                  step_n    = 1'b1;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
         end
         OVER: begin
            timer_n = '0;
            if (restart) begin
               state_n   = IDLE;
               x_n       = XW'(START_X);
               y_n       = YW'(START_Y);
               cur_dir_n = 2'd1;
               pending_n = 2'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         pending <= 2'd1;
         cur_dir <= 2'd1;
         head_x  <= XW'(START_X);
         head_y  <= YW'(START_Y);
         step    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         pending <= pending_n;
         cur_dir <= cur_dir_n;
         head_x  <= x_n;
         head_y  <= y_n;
         step    <= step_n;
         running <= (state_n == RUN);
      end
   end
endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Randomised bench for snake_motion_ctrl against a cycle-level behavioural model.
module tb_snake_motion_ctrl;
   localparam int TICK = 8;
   localparam int GW   = 40;
   localparam int GH   = 30;

   logic       clk_25 = 1'b0;
   logic       rst;
   logic [2:0] direction;
   logic       game_over, restart;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [1:0] cur_dir;
   logic       step, running;

   int n_chk = 0, n_pass = 0, steps_seen = 0;

   snake_motion_ctrl #(.TICK_CYCLES(TICK), .GRID_W(GW), .GRID_H(GH), .XW(6), .YW(5),
                       .START_X(20), .START_Y(15)) dut (
      .clk_25(clk_25), .rst(rst), .direction(direction), .game_over(game_over),
      .restart(restart), .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
      .step(step), .running(running));

   always #5 clk_25 = ~clk_25;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Model: mode 0=idle 1=run 2=over; directions as (dx,dy) with modulo wrap
   int m_s[3];
   int m_mode, m_pend, m_dir, m_tick, m_x, m_y, m_step, m_run;
   int dxs[4] = '{0, 1, -1, 0};
   int dys[4] = '{1, 0, 0, -1};

   always @(posedge clk_25 or posedge rst) begin
      int cand, mv;
      if (rst) begin
         m_s = '{4, 4, 4};
         m_mode = 0; m_pend = 1; m_dir = 1; m_tick = 0;
         m_x = 20; m_y = 15; m_step = 0; m_run = 0;
      end else begin
         cand = (m_s[1] == m_s[2] && m_s[2] < 4) ? m_s[2] : -1;
         m_step = 0;
         case (m_mode)
            0: if (cand >= 0) begin m_pend = cand; m_dir = cand; m_mode = 1; end
            1: if (game_over) begin
                  m_mode = 2; m_tick = 0;
               end else begin
                  mv = m_pend;
                  if (cand >= 0 && cand + m_dir != 3) m_pend = cand;
                  if (m_tick == TICK-1) begin
                     m_tick = 0; m_dir = mv; m_step = 1;
                     m_x = (m_x + dxs[mv] + GW) % GW;
                     m_y = (m_y + dys[mv] + GH) % GH;
                  end else m_tick++;
               end
            default: if (restart) begin
                  m_mode = 0; m_x = 20; m_y = 15; m_dir = 1; m_pend = 1;
               end
         endcase
         m_run = (m_mode == 1);
         m_s[2] = m_s[1]; m_s[1] = m_s[0]; m_s[0] = int'(direction);
      end
   end

   always @(negedge clk_25) if (!rst) begin
      chk("head_x", head_x, m_x);
      chk("head_y", head_y, m_y);
      chk("cur_dir", cur_dir, m_dir);
      chk("step", step, m_step);
      chk("running", running, m_run);
      if (step) steps_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_25);
   endtask

   task automatic wait_step(input string tag);
      int k = 0;
      do begin @(negedge clk_25); k++; end while (!step && k < 3*TICK);
      chk(tag, step, 1);
   endtask

   task automatic wait_run(input string tag, input int budget);
      int k = 0;
      do begin @(negedge clk_25); k++; end while (!running && k < budget);
      chk(tag, running, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"}, head_x, 20);
      chk({tag, "_y"}, head_y, 15);
      chk({tag, "_dir"}, cur_dir, 1);
      chk({tag, "_step"}, step, 0);
      chk({tag, "_run"}, running, 0);
   endtask

   initial begin
      int x0, y0, k, s0;
      direction = 3'd4; game_over = 1'b0; restart = 1'b0; rst = 1'b0;
      #1 rst = 1'b1;
      #1 chk_reset_vals("rst");
      cyc(2);
      rst = 1'b0;
      s0 = steps_seen;
      cyc(50);
      chk("idle_nostep", steps_seen - s0, 0);

      // Start moving up; steps at head_y 14 then 13
      direction = 3'd3;
      wait_run("run_lat", 5);
      wait_step("step_up1"); chk("y_up1", head_y, 14);
      wait_step("step_up2"); chk("y_up2", head_y, 13);

      // Turn right, then reversal to left must be ignored
      direction = 3'd1;
      wait_step("step_r0");
      wait_step("step_r1");
      direction = 3'd2;
      for (int i = 0; i < 3; i++) begin
         x0 = head_x;
         wait_step("step_rev");
         chk("rev_rej_x", head_x, (x0 + 1) % GW);
      end

      // Moving right: 3 then 2 within one tick -> move is up
      direction = 3'd1;
      wait_step("step_r2");
      wait_step("step_r3");
      direction = 3'd3;
      cyc(4);
      direction = 3'd2;
      y0 = head_y;
      wait_step("step_turn");
      chk("turn_dir", cur_dir, 3);
      chk("turn_y", head_y, (y0 + GH - 1) % GH);

      // Right-edge wrap
      direction = 3'd1;
      cyc(5);
      k = 0;
      while (!(head_x == 39 && cur_dir == 1) && k < 60) begin wait_step("step_wx"); k++; end
      wait_step("step_wrapx");
      chk("wrap_x", head_x, 0);

      // Top-edge wrap
      direction = 3'd3;
      k = 0;
      while (!(head_y == 0 && cur_dir == 3) && k < 40) begin wait_step("step_wy"); k++; end
      wait_step("step_wrapy");
      chk("wrap_y", head_y, 29);

      // game_over on the timer-expiry edge wins
      k = 0;
      while (!(m_mode == 1 && m_tick == TICK-1) && k < 20) begin cyc(1); k++; end
      x0 = head_x; y0 = head_y;
      game_over = 1'b1;
      cyc(1);
      game_over = 1'b0;
      chk("go_nostep", step, 0);
      chk("go_x", head_x, x0);
      chk("go_y", head_y, y0);
      chk("go_run", running, 0);
      for (int i = 0; i < 30; i++) begin direction = 3'($urandom_range(0, 7)); cyc(1); end
      chk("over_x", head_x, x0);
      chk("over_y", head_y, y0);
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      chk_reset_vals("restart");

      // Async reset mid-run
      direction = 3'd0;
      wait_run("run_lat2", 6);
      cyc(13);
      rst = 1'b1;
      #1 chk_reset_vals("midrst");
      cyc(1);
      rst = 1'b0;

      // Random traffic, including stray game_over/restart pulses
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) direction = 3'($urandom_range(0, 7));
         game_over = ($urandom_range(0, 199) == 0);
         restart   = ($urandom_range(0, 49) == 0);
         cyc(1);
      end
      game_over = 1'b0; restart = 1'b0;
      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
